// File: rtl/mastermind_pkg.sv
// Shared constants for the Mastermind round tracker: game geometry, the
// external state_out encoding and the internal FSM encoding (adds CHECK).
package mastermind_pkg;

    localparam int NUM_PEGS    = 4;
    localparam int PEG_W       = 3;
    localparam int MAX_GUESSES = 8;
    localparam int CNT_W       = 4;

    localparam logic [1:0] OUT_IDLE    = 2'd0;
    localparam logic [1:0] OUT_PLAYING = 2'd1;
    localparam logic [1:0] OUT_WON     = 2'd2;
    localparam logic [1:0] OUT_LOST    = 2'd3;

    // Low two bits of the visible states match the external encoding.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PLAYING = 3'd1;
    localparam logic [2:0] ST_WON     = 3'd2;
    localparam logic [2:0] ST_LOST    = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;

    function automatic logic [1:0] state_to_out(input logic [2:0] st);
        if (st == ST_CHECK) begin
            return OUT_PLAYING;
        end
        return st[1:0];
    endfunction

endpackage

// File: rtl/score_history_mem.sv
// Per-game score history: MAX_GUESSES entries of {valid, red, white}, one
// write port, synchronous clear-all, one combinational read port (pre-edge data).
module score_history_mem
    import mastermind_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_idx,
    input  logic [PEG_W-1:0] wr_red,
    input  logic [PEG_W-1:0] wr_white,
    input  logic [CNT_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [PEG_W-1:0] rd_red,
    output logic [PEG_W-1:0] rd_white
);

    logic [MAX_GUESSES-1:0] valid_q, valid_d;
    logic [PEG_W-1:0]       red_q   [MAX_GUESSES];
    logic [PEG_W-1:0]       red_d   [MAX_GUESSES];
    logic [PEG_W-1:0]       white_q [MAX_GUESSES];
    logic [PEG_W-1:0]       white_d [MAX_GUESSES];

    always_comb begin
        valid_d = valid_q;
        red_d   = red_q;
        white_d = white_q;
        if (clr) begin
            valid_d = '0;
            for (int i = 0; i < MAX_GUESSES; i++) begin
                red_d[i]   = '0;
                white_d[i] = '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < MAX_GUESSES; i++) begin
                if (wr_idx == CNT_W'(i)) begin
                    valid_d[i] = 1'b1;
                    red_d[i]   = wr_red;
                    white_d[i] = wr_white;
                end
            end
        end
    end

    // Out-of-range indices match no entry and read back as invalid zeros.
    always_comb begin
        rd_valid = 1'b0;
        rd_red   = '0;
        rd_white = '0;
        for (int i = 0; i < MAX_GUESSES; i++) begin
            if (rd_idx == CNT_W'(i)) begin
                rd_valid = valid_q[i];
                rd_red   = red_q[i];
                rd_white = white_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < MAX_GUESSES; i++) begin
                red_q[i]   <= '0;
                white_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < MAX_GUESSES; i++) begin
                red_q[i]   <= red_d[i];
                white_q[i] <= white_d[i];
            end
        end
    end

endmodule

// File: rtl/mastermind_round_tracker.sv
// Round tracker: counts scored guesses, records history, decides win/loss.
// Verdict appears one cycle after the accepted score (CHECK state); win/lose pulses align with it.
module mastermind_round_tracker
    import mastermind_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             new_game,
    input  logic             result_valid,
    input  logic [PEG_W-1:0] red_in,
    input  logic [PEG_W-1:0] white_in,
    input  logic [CNT_W-1:0] hist_sel,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] guess_count,
    output logic [PEG_W-1:0] disp_red,
    output logic [PEG_W-1:0] disp_white,
    output logic [PEG_W-1:0] hist_red,
    output logic [PEG_W-1:0] hist_white,
    output logic             hist_valid,
    output logic             win_pulse,
    output logic             lose_pulse,
    output logic             bad_score,
    output logic             overrun
);

    localparam logic [PEG_W:0]   PEGS_SUM = (PEG_W+1)'(NUM_PEGS);
    localparam logic [PEG_W-1:0] PEGS_CNT = PEG_W'(NUM_PEGS);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_GUESSES);

    logic [2:0]       state_q, state_d;
    logic [1:0]       state_out_q, state_out_d;
    logic [CNT_W-1:0] guess_count_q, guess_count_d;
    logic [PEG_W-1:0] disp_red_q, disp_red_d;
    logic [PEG_W-1:0] disp_white_q, disp_white_d;
    logic             win_pulse_q, win_pulse_d;
    logic             lose_pulse_q, lose_pulse_d;
    logic             bad_score_q, bad_score_d;
    logic             overrun_q, overrun_d;

    logic             hist_clr;
    logic             hist_wr;
    logic [PEG_W:0]   peg_sum;
    logic             score_bad;
    logic             rd_valid;
    logic [PEG_W-1:0] rd_red, rd_white;
    logic             sel_in_range;

    // One extra bit so e.g. 4+4 cannot wrap back into the legal range.
    assign peg_sum   = {1'b0, red_in} + {1'b0, white_in};
    assign score_bad = (peg_sum > PEGS_SUM) || ({1'b0, red_in} > PEGS_SUM);

    always_comb begin
        state_d       = state_q;
        guess_count_d = guess_count_q;
        disp_red_d    = disp_red_q;
        disp_white_d  = disp_white_q;
        win_pulse_d   = 1'b0;
        lose_pulse_d  = 1'b0;
        bad_score_d   = bad_score_q;
        overrun_d     = overrun_q;
        hist_clr      = 1'b0;
        hist_wr       = 1'b0;

        if (new_game) begin
            state_d       = ST_PLAYING;
            guess_count_d = '0;
            disp_red_d    = '0;
            disp_white_d  = '0;
            bad_score_d   = 1'b0;
            overrun_d     = 1'b0;
            hist_clr      = 1'b1;
        end else begin
            case (state_q)
                ST_PLAYING: begin
                    if (result_valid) begin
                        if (score_bad) begin
                            bad_score_d = 1'b1;
                        end else begin
                            hist_wr       = 1'b1;
                            disp_red_d    = red_in;
                            disp_white_d  = white_in;
                            guess_count_d = guess_count_q + CNT_W'(1);
                            state_d       = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    overrun_d = overrun_q | result_valid;
                    // Win is tested first so a winning final guess is not a loss.
                    if (disp_red_q == PEGS_CNT) begin
                        state_d     = ST_WON;
                        win_pulse_d = 1'b1;
                    end else if (guess_count_q == MAX_CNT) begin
                        state_d      = ST_LOST;
                        lose_pulse_d = 1'b1;
                    end else begin
                        state_d = ST_PLAYING;
                    end
                end
                default: begin
                    overrun_d = overrun_q | result_valid;
                end
            endcase
        end

        state_out_d = state_to_out(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            state_out_q   <= OUT_IDLE;
            guess_count_q <= '0;
            disp_red_q    <= '0;
            disp_white_q  <= '0;
            win_pulse_q   <= 1'b0;
            lose_pulse_q  <= 1'b0;
            bad_score_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            state_out_q   <= state_out_d;
            guess_count_q <= guess_count_d;
            disp_red_q    <= disp_red_d;
            disp_white_q  <= disp_white_d;
            win_pulse_q   <= win_pulse_d;
            lose_pulse_q  <= lose_pulse_d;
            bad_score_q   <= bad_score_d;
            overrun_q     <= overrun_d;
        end
    end

    score_history_mem u_hist (
        .clk      (clk),
        .reset    (reset),
        .clr      (hist_clr),
        .wr_en    (hist_wr),
        .wr_idx   (guess_count_q),
        .wr_red   (red_in),
        .wr_white (white_in),
        .rd_idx   (hist_sel),
        .rd_valid (rd_valid),
        .rd_red   (rd_red),
        .rd_white (rd_white)
    );

    assign sel_in_range = (hist_sel < guess_count_q) && (hist_sel < MAX_CNT);

    assign hist_valid  = sel_in_range & rd_valid;
    assign hist_red    = sel_in_range ? rd_red   : '0;
    assign hist_white  = sel_in_range ? rd_white : '0;

    assign state_out   = state_out_q;
    assign guess_count = guess_count_q;
    assign disp_red    = disp_red_q;
    assign disp_white  = disp_white_q;
    assign win_pulse   = win_pulse_q;
    assign lose_pulse  = lose_pulse_q;
    assign bad_score   = bad_score_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/mastermind_round_tracker.md
Name: mastermind_round_tracker

Overview:
Downstream of the guess-scoring datapath. Each time a guess has been scored, the tracker takes the final red/white peg counts. It counts guesses, keeps a history of every score in the current game, and decides win or loss. It also drives the score and status values that the top level sends to the HEX displays.

Parameters:
NUM_PEGS, 4, code length; a score with red == NUM_PEGS is a win
PEG_W, 3, width of the red/white count fields
MAX_GUESSES, 8, guesses allowed per game; also the history depth
CNT_W, 4, width of the guess counter; must satisfy 2^CNT_W > MAX_GUESSES

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
new_game  in  1  single-cycle pulse; clears game state and starts play
result_valid  in  1  single-cycle pulse; red_in/white_in are final for the current guess
red_in  in  PEG_W  red count (right colour, right position)
white_in  in  PEG_W  white count (right colour, wrong position)
hist_sel  in  CNT_W  index of the history entry to view (0 = first guess)
state_out  out  2  IDLE=0, PLAYING=1, WON=2, LOST=3
guess_count  out  CNT_W  number of accepted guesses in this game
disp_red  out  PEG_W  red count of the last accepted guess
disp_white  out  PEG_W  white count of the last accepted guess
hist_red  out  PEG_W  red count of entry hist_sel
hist_white  out  PEG_W  white count of entry hist_sel
hist_valid  out  1  entry hist_sel holds a guess from this game
win_pulse  out  1  one-cycle pulse on entry to WON
lose_pulse  out  1  one-cycle pulse on entry to LOST
bad_score  out  1  sticky: a malformed score was rejected
overrun  out  1  sticky: result_valid arrived while not accepting

Behaviour:
- Reset (sync, high): state IDLE; guess_count=0; disp_*=0; all history entries invalid and zero; win_pulse, lose_pulse, bad_score and overrun all 0. Reset overrides every other input.
- Internal state machine is IDLE, PLAYING, CHECK, WON, LOST. CHECK is reported on state_out as PLAYING.
- new_game, in any state: next cycle the state is PLAYING, guess_count=0, all history invalid, disp_*=0, bad_score=0, overrun=0. If result_valid arrives in the same cycle, new_game wins and the result is dropped silently, with no overrun.
- PLAYING with result_valid:
  - If red_in + white_in > NUM_PEGS, or red_in > NUM_PEGS: reject the score, set bad_score, leave the count unchanged, stay in PLAYING. The sum is computed at PEG_W+1 bits.
  - Otherwise, at the clock edge: history[guess_count] <= {red_in, white_in} marked valid; disp_* <= inputs; guess_count increments; state goes to CHECK.
- CHECK lasts one cycle. Evaluate the stored last score in this order:
  - disp_red == NUM_PEGS -> WON, win_pulse high for that one cycle.
  - else guess_count == MAX_GUESSES -> LOST, lose_pulse high for that one cycle.
  - else -> PLAYING.
  - A win on the final guess is WON, not LOST.
- Latency: result_valid at edge N, state_out becomes WON/LOST/PLAYING after edge N+1. This is why the pulses are aligned with the state entry.
- result_valid in IDLE, CHECK, WON or LOST: ignored, sets overrun, all stored state unchanged.
- WON and LOST are absorbing; only new_game or reset leaves them. disp_* keep the final score.
- guess_count never exceeds MAX_GUESSES and never wraps.
- History read is combinational from the registered entries:
  - hist_sel >= guess_count or hist_sel >= MAX_GUESSES -> hist_valid=0, hist_red=0, hist_white=0.
  - A write and a read of the same index in one cycle returns the old (pre-edge) contents.
- All outputs are registered except hist_red, hist_white and hist_valid.

Decomposition:
- Shared package mastermind_pkg holds:
  - NUM_PEGS, PEG_W and MAX_GUESSES constants;
  - the state_out encoding constants (IDLE/PLAYING/WON/LOST);
  - the internal CHECK encoding.
- One sub-module, score_history_mem: a MAX_GUESSES-entry register file of {valid, red, white}. It has a write port (wr_en, wr_idx, data), a synchronous clear-all, and one combinational read port.
- The state machine, counter, validity check and sticky flags stay in mastermind_round_tracker.

Test Plan:
- Reset, then new_game, then score (1,2) -> guess_count=1, disp=(1,2); one cycle later state_out=PLAYING; hist_sel=0 gives hist_valid=1, (1,2).
- Scores (0,1), (2,1), (4,0) -> after the third result, guess_count=3; the next cycle state_out=WON with win_pulse=1 for exactly one cycle; a further result_valid leaves guess_count=3 and sets overrun.
- Eight non-winning scores (1,1) -> after the eighth, state LOST with lose_pulse for one cycle, guess_count=8; hist_sel=7 is valid, hist_sel=8 is invalid with zero outputs.
- A winning score (4,0) as the eighth guess -> WON, lose_pulse never asserted.
- Score (3,2) or (5,0) while PLAYING -> bad_score=1, guess_count unchanged, state PLAYING; then new_game -> bad_score=0 and the history is cleared.
- new_game and result_valid in the same cycle mid-game -> guess_count=0, no overrun. A result_valid on the cycle right after an accepted one (CHECK cycle) -> ignored, overrun=1. Reset asserted in WON -> IDLE with all outputs zero.
